// File: rtl/uart_tx_engine.sv
// UART transmitter: pops words from the TX FIFO and serialises them as
// start, DBits data (LSB first), optional even parity, then stop.
module uart_tx_engine #(
  parameter int unsigned DBits     = 8,
  parameter int unsigned SB_TICK   = 16,
  parameter bit          PARITY_EN = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_areset,
  input  logic             i_s_tick,
  input  logic             i_fifo_empty,
  input  logic [DBits-1:0] i_fifo_data,
  output logic             o_fifo_rd_en,
  output logic             o_tx,
  output logic             o_tx_busy,
  output logic             o_tx_done_tick
);

  localparam int unsigned TickSpan = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int unsigned TickW    = $clog2(TickSpan);
  localparam int unsigned BitW     = (DBits > 1) ? $clog2(DBits) : 1;
  localparam logic [TickW-1:0] TickBitLast  = TickW'(15);
  localparam logic [TickW-1:0] TickStopLast = TickW'(SB_TICK - 1);
  localparam logic [BitW-1:0]  BitLast      = BitW'(DBits - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StStart, StData, StParity, StStop
  } state_e;

  state_e             r_state, w_state_d;
  logic [TickW-1:0]   r_tick, w_tick_d;
  logic [BitW-1:0]    r_bit, w_bit_d;
  logic [DBits-1:0]   r_shreg, w_shreg_d;
  logic               r_parity, w_parity_d;
  logic               r_tx, w_tx_d;
  logic               r_done, w_done_d;
  logic               w_rd_en;

  always_comb begin
    w_state_d  = r_state;
    w_tick_d   = r_tick;
    w_bit_d    = r_bit;
    w_shreg_d  = r_shreg;
    w_parity_d = r_parity;
    w_done_d   = 1'b0;
    w_rd_en    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!i_fifo_empty) begin
          w_rd_en   = 1'b1;
          w_state_d = StFetch;
        end
      end
      StFetch: begin
        w_shreg_d  = i_fifo_data;
        w_parity_d = ^i_fifo_data;
        w_tick_d   = '0;
        w_state_d  = StStart;
      end
      StStart: begin
        if (i_s_tick) begin
          if (r_tick == TickBitLast) begin
            w_tick_d  = '0;
            w_bit_d   = '0;
            w_state_d = StData;
          end else begin
            w_tick_d = r_tick + 1'b1;
          end
        end
      end
      StData: begin
        if (i_s_tick) begin
          if (r_tick == TickBitLast) begin
            w_tick_d  = '0;
            w_shreg_d = r_shreg >> 1;
            if (r_bit == BitLast) begin
              w_state_d = PARITY_EN ? StParity : StStop;
            end else begin
              w_bit_d = r_bit + 1'b1;
            end
          end else begin
            w_tick_d = r_tick + 1'b1;
          end
        end
      end
      StParity: begin
        if (i_s_tick) begin
          if (r_tick == TickBitLast) begin
            w_tick_d  = '0;
            w_state_d = StStop;
          end else begin
            w_tick_d = r_tick + 1'b1;
          end
        end
      end
      StStop: begin
        if (i_s_tick) begin
          if (r_tick == TickStopLast) begin
            w_tick_d  = '0;
            w_done_d  = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_tick_d = r_tick + 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Line level follows the next state so the registered tx lines up with it.
  always_comb begin
    w_tx_d = 1'b1;
    case (w_state_d)
      StStart:  w_tx_d = 1'b0;
      StData:   w_tx_d = w_shreg_d[0];
      StParity: w_tx_d = w_parity_d;
      default:  w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_areset) begin
    if (!i_areset) begin
      r_state  <= StIdle;
      r_tick   <= '0;
      r_bit    <= '0;
      r_shreg  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_tick   <= w_tick_d;
      r_bit    <= w_bit_d;
      r_shreg  <= w_shreg_d;
      r_parity <= w_parity_d;
      r_tx     <= w_tx_d;
      r_done   <= w_done_d;
    end
  end

  // Gated so no pop can escape while reset is held.
  assign o_fifo_rd_en   = w_rd_en & i_areset;
  assign o_tx           = r_tx;
  assign o_tx_busy      = (r_state != StIdle);
  assign o_tx_done_tick = r_done;

endmodule
